multiplier_seq_nbit: RTL and testbench
======================================

# multiplier_seq_nbit

Parametrised sequential shift-add multiplier with a start/done handshake, selectable unsigned/signed operation, full 2N-bit product and N-bit truncated result with ALU-style status flags. It is the next-generation multiplier for the lab ALU datapath: it replaces the fixed 4-bit, reset-triggered unit with a width-generic, handshaked unit that the ALU control FSM can launch and poll.

## Interface
- N, default 4: operand width; legal N >= 2.
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- start  input  1  launch request; accepted only in IDLE or DONE.
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- A  input  N  multiplicand; sampled with start.
- B  input  N  multiplier; sampled with start.
- busy  output  1  high while in CALC.
- done  output  1  one-cycle pulse when outputs update.
- product  output  2N  full product.
- result  output  N  product[N-1:0].
- overflow  output  1  product not representable in N bits in the captured mode.
- zero  output  1  result == 0.
- carry_out  output  1  unsigned mode: |product[2N-1:N]; signed mode: 0.
- negative  output  1  result[N-1].

## Operation
- States: IDLE, CALC, DONE.
- IDLE: start=1 -> latch A, B, signed_mode; go CALC; iteration counter = 0.
- CALC: one radix-2 shift-add iteration per cycle on latched operands; exactly N iterations; after the Nth go DONE.
- DONE: done=1 for exactly one cycle; next state IDLE, or CALC if start=1 (back-to-back launch with fresh operand capture).
- start while in CALC: ignored; no restart, no queuing.
- A, B, signed_mode changes after capture: no effect on the running operation.
- Signed mode: capture magnitudes |A|, |B| (N+1-bit internal to handle most-negative value), multiply unsigned, negate 2N-bit product if sign(A) xor sign(B).
- overflow: unsigned -> product[2N-1:N] != 0; signed -> product[2N-1:N-1] not all equal.
- product, result and all flags are registered; they update only on the edge entering DONE and hold until the next DONE or reset.
- Reset: state IDLE; busy=0, done=0, product=0, result=0, overflow=0, carry_out=0, negative=0, zero=1 (follows result==0). rst during CALC aborts the operation; no done pulse follows.
- rst and start asserted together: rst wins; start ignored.

## Timing
- start sampled at rising edge k (state IDLE/DONE): busy=1 from edge k through edge k+N.
- Iterations at edges k+1 .. k+N; outputs and done updated at edge k+N.
- done high from edge k+N to edge k+N+1; busy low in that cycle.
- Latency: N cycles from start edge to done (4 cycles for N=4). Throughput: one multiply per N cycles with back-to-back starts in DONE.
- No combinational path from inputs to outputs.

## Configuration
- MULTIPLIER_SIGNED_EN defined: signed_mode honoured as above.
- MULTIPLIER_SIGNED_EN undefined: signed-mode logic (magnitude capture, final negation, signed overflow) compiled out; signed_mode port kept but ignored; all operations unsigned; carry_out = overflow = |product[2N-1:N].

## Test plan
- N=4, unsigned: A=0101, B=0010, pulse start -> after 4 cycles done=1, product=0x0A, result=1010, overflow=0, negative=1, zero=0.
- N=4, unsigned back-to-back: (1011x0010), (1001x0101), (1111x1111) with start held in each DONE -> results 0110 / 1101 / 0001, products 0x16 / 0x2D / 0xE1, overflow=carry_out=1 each, done every 4 cycles.
- N=4, signed (MULTIPLIER_SIGNED_EN): A=1011 (-5), B=0010 -> product=0xF6, result=0110, overflow=1, carry_out=0; A=1000, B=1000 -> product=0x40, overflow=1; A=1111, B=0011 -> product=0xFD, result=1101, overflow=0, negative=1.
- Protocol: start pulsed again mid-CALC with different A -> ignored, done at original time with original product; operand change after capture -> no effect.
- Reset: rst asserted in 2nd CALC cycle -> next cycle busy=0, outputs at reset values, no done pulse; zero-operand A=0000, B=1011 -> product=0, zero=1.
- N=8 unsigned: A=0xFF, B=0xFF -> done 8 cycles after start, product=0xFE01, result=0x01, overflow=1.

Source files
------------

// File: rtl/multiplier_seq_nbit.sv
// multiplier_seq_nbit: sequential radix-2 shift-add multiplier with a start/done
// handshake. It produces the full 2N-bit product and an N-bit truncated result
// with ALU-style status flags. The multiply takes N cycles from the start edge.
// Optional feature macro MULTIPLIER_SIGNED_EN enables two's-complement operation
// through signed_mode. Without the macro, signed_mode is ignored and every
// operation is unsigned.
module multiplier_seq_nbit #(
    parameter int unsigned N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [N-1:0]     A,
    input  logic [N-1:0]     B,
    output logic             busy,
    output logic             done,
    output logic [2*N-1:0]   product,
    output logic [N-1:0]     result,
    output logic             overflow,
    output logic             zero,
    output logic             carry_out,
    output logic             negative
);

    localparam int unsigned PW = 2 * N;
    localparam int unsigned MW = N + 1;
    localparam int unsigned CW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            launch_c;
    logic            last_c;

    logic [PW-1:0]   mcand;
    logic [MW-1:0]   mplier;
    logic [PW-1:0]   acc;
    logic [CW-1:0]   cnt;

    logic [MW-1:0]   a_mag_c;
    logic [MW-1:0]   b_mag_c;
    logic [PW-1:0]   acc_nxt_c;
    logic [PW-1:0]   prod_c;
    logic            ovf_c;
    logic            cry_c;

`ifdef MULTIPLIER_SIGNED_EN
    logic            neg_q;
    logic            sm_q;
    logic            neg_c;
    logic [MW-1:0]   a_ext_c;
    logic [MW-1:0]   b_ext_c;

    // Operand magnitudes are one bit wider so the most-negative value stays positive.
    always_comb begin
        a_ext_c = {signed_mode & A[N-1], A};
        b_ext_c = {signed_mode & B[N-1], B};
        a_mag_c = a_ext_c[N] ? -a_ext_c : a_ext_c;
        b_mag_c = b_ext_c[N] ? -b_ext_c : b_ext_c;
        neg_c   = signed_mode & (A[N-1] ^ B[N-1]);
    end

    // Final accumulate, sign restore and flag derivation for the last iteration.
    always_comb begin
        acc_nxt_c = acc + (mplier[0] ? mcand : '0);
        prod_c    = neg_q ? -acc_nxt_c : acc_nxt_c;
        if (sm_q) begin
            ovf_c = !((&prod_c[PW-1:N-1]) | ~(|prod_c[PW-1:N-1]));
            cry_c = 1'b0;
        end else begin
            ovf_c = |prod_c[PW-1:N];
            cry_c = |prod_c[PW-1:N];
        end
    end
`else
    logic            unused_signed_mode;
    assign unused_signed_mode = signed_mode;

    // Unsigned-only build: operands are used as they are.
    always_comb begin
        a_mag_c = {1'b0, A};
        b_mag_c = {1'b0, B};
    end

    // Final accumulate and flag derivation for the last iteration.
    always_comb begin
        acc_nxt_c = acc + (mplier[0] ? mcand : '0);
        prod_c    = acc_nxt_c;
        ovf_c     = |prod_c[PW-1:N];
        cry_c     = |prod_c[PW-1:N];
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic, start acceptance and detection of the last iteration.
    always_comb begin
        state_nxt = state;
        launch_c  = 1'b0;
        last_c    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    launch_c  = 1'b1;
                    state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                if (cnt == CW'(N - 1)) begin
                    last_c    = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    launch_c  = 1'b1;
                    state_nxt = S_CALC;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: capture operands, iterate, and register outputs on the edge entering DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
            product   <= '0;
            result    <= '0;
            overflow  <= 1'b0;
            zero      <= 1'b1;
            carry_out <= 1'b0;
            negative  <= 1'b0;
`ifdef MULTIPLIER_SIGNED_EN
            neg_q     <= 1'b0;
            sm_q      <= 1'b0;
`endif
        end else begin
            busy <= (state_nxt == S_CALC);
            done <= (state_nxt == S_DONE);
            if (launch_c) begin
                mcand  <= PW'(a_mag_c);
                mplier <= b_mag_c;
                acc    <= '0;
                cnt    <= '0;
`ifdef MULTIPLIER_SIGNED_EN
                neg_q  <= neg_c;
                sm_q   <= signed_mode;
`endif
            end else if (state == S_CALC) begin
                acc    <= acc_nxt_c;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CW'(1);
                if (last_c) begin
                    product   <= prod_c;
                    result    <= prod_c[N-1:0];
                    overflow  <= ovf_c;
                    carry_out <= cry_c;
                    zero      <= ~(|prod_c[N-1:0]);
                    negative  <= prod_c[N-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_multiplier_seq_nbit.sv
// Directed testbench for multiplier_seq_nbit (N=4 and N=8 instances).
module tb_multiplier_seq_nbit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_mode;
    logic [3:0]  A;
    logic [3:0]  B;
    logic        busy;
    logic        done;
    logic [7:0]  product;
    logic [3:0]  result;
    logic        overflow;
    logic        zero;
    logic        carry_out;
    logic        negative;

    logic        start8;
    logic [7:0]  A8;
    logic [7:0]  B8;
    logic        busy8;
    logic        done8;
    logic [15:0] product8;
    logic [7:0]  result8;
    logic        overflow8;
    logic        zero8;
    logic        carry8;
    logic        negative8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multiplier_seq_nbit #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
        .A(A), .B(B), .busy(busy), .done(done), .product(product),
        .result(result), .overflow(overflow), .zero(zero),
        .carry_out(carry_out), .negative(negative)
    );

    multiplier_seq_nbit #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(1'b0),
        .A(A8), .B(B8), .busy(busy8), .done(done8), .product(product8),
        .result(result8), .overflow(overflow8), .zero(zero8),
        .carry_out(carry8), .negative(negative8)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {busy, done, overflow, carry_out, zero, negative}
    function automatic logic [5:0] flags4();
        return {busy, done, overflow, carry_out, zero, negative};
    endfunction

    task automatic launch4(input logic [3:0] a, input logic [3:0] b, input logic sm);
        A = a; B = b; signed_mode = sm; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done4(input string tag);
        int cyc;
        cyc = 0;
        while (!done && cyc < 20) begin
            tick();
            cyc++;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'd4);
    endtask

    initial begin
        int pulses;
        int cyc8;
        rst = 1'b1; start = 1'b0; signed_mode = 1'b0; A = '0; B = '0;
        start8 = 1'b0; A8 = '0; B8 = '0;
        tick(); tick();
        rst = 1'b0;
        chk("reset_flags", 64'(flags4()), 64'b000010);
        chk("reset_product", 64'(product), 64'h0);

        // Basic unsigned multiply
        launch4(4'b0101, 4'b0010, 1'b0);
        chk("u1_busy", 64'(busy), 64'd1);
        wait_done4("u1");
        chk("u1_product", 64'(product), 64'h0A);
        chk("u1_result", 64'(result), 64'hA);
        chk("u1_flags", 64'(flags4()), 64'b010001);
        tick();
        chk("u1_done_pulse", 64'(done), 64'd0);
        chk("u1_hold", 64'(product), 64'h0A);

        // Back-to-back launches with start asserted in DONE
        launch4(4'b1011, 4'b0010, 1'b0);
        wait_done4("b2b1");
        chk("b2b1_product", 64'(product), 64'h16);
        chk("b2b1_flags", 64'(flags4()), 64'b011100);
        launch4(4'b1001, 4'b0101, 1'b0);
        wait_done4("b2b2");
        chk("b2b2_product", 64'(product), 64'h2D);
        chk("b2b2_flags", 64'(flags4()), 64'b011101);
        launch4(4'b1111, 4'b1111, 1'b0);
        wait_done4("b2b3");
        chk("b2b3_product", 64'(product), 64'hE1);
        chk("b2b3_result", 64'(result), 64'h1);
        chk("b2b3_flags", 64'(flags4()), 64'b011100);
        tick();

`ifdef MULTIPLIER_SIGNED_EN
        launch4(4'b1011, 4'b0010, 1'b1);
        wait_done4("s1");
        chk("s1_product", 64'(product), 64'hF6);
        chk("s1_flags", 64'(flags4()), 64'b010100);
        launch4(4'b1000, 4'b1000, 1'b1);
        wait_done4("s2");
        chk("s2_product", 64'(product), 64'h40);
        chk("s2_flags", 64'(flags4()), 64'b010110);
        launch4(4'b1111, 4'b0011, 1'b1);
        wait_done4("s3");
        chk("s3_product", 64'(product), 64'hFD);
        chk("s3_flags", 64'(flags4()), 64'b010001);
`else
        // signed_mode is ignored in the unsigned-only build
        launch4(4'b1011, 4'b0010, 1'b1);
        wait_done4("s1");
        chk("s1_product", 64'(product), 64'h16);
        chk("s1_flags", 64'(flags4()), 64'b011100);
        launch4(4'b1000, 4'b1000, 1'b1);
        wait_done4("s2");
        chk("s2_product", 64'(product), 64'h40);
        chk("s2_flags", 64'(flags4()), 64'b011110);
        launch4(4'b1111, 4'b0011, 1'b1);
        wait_done4("s3");
        chk("s3_product", 64'(product), 64'h2D);
        chk("s3_flags", 64'(flags4()), 64'b011101);
`endif
        tick();

        // A start during CALC and operand changes after capture have no effect
        launch4(4'b0011, 4'b0011, 1'b0);
        tick();
        start = 1'b1; A = 4'b1111; B = 4'b1111; signed_mode = 1'b1;
        tick();
        start = 1'b0;
        chk("proto_busy", 64'(busy), 64'd1);
        tick();
        chk("proto_early", 64'(done), 64'd0);
        tick();
        chk("proto_done", 64'(done), 64'd1);
        chk("proto_product", 64'(product), 64'h09);
        chk("proto_flags", 64'(flags4()), 64'b010001);
        tick();

        // Reset in the second CALC cycle aborts with no done pulse
        launch4(4'b0101, 4'b0011, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_flags", 64'(flags4()), 64'b000010);
        chk("abort_product", 64'(product), 64'h0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) pulses++;
        end
        chk("abort_no_done", 64'(pulses), 64'd0);

        // Reset wins over a simultaneous start
        rst = 1'b1; start = 1'b1; A = 4'b0101; B = 4'b0011;
        tick();
        rst = 1'b0; start = 1'b0;
        chk("rst_start_busy", 64'(busy), 64'd0);
        tick();
        chk("rst_start_idle", 64'(busy), 64'd0);

        // Zero operand
        launch4(4'b0000, 4'b1011, 1'b0);
        wait_done4("zero");
        chk("zero_product", 64'(product), 64'h0);
        chk("zero_flags", 64'(flags4()), 64'b010010);
        tick();

        // N=8 full-scale unsigned
        A8 = 8'hFF; B8 = 8'hFF; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        cyc8 = 0;
        while (!done8 && cyc8 < 40) begin
            tick();
            cyc8++;
        end
        chk("n8_latency", 64'(cyc8), 64'd8);
        chk("n8_product", 64'(product8), 64'hFE01);
        chk("n8_result", 64'(result8), 64'h01);
        chk("n8_flags", 64'({busy8, done8, overflow8, carry8, zero8, negative8}), 64'b011100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
